dmx8_32bits_reg: RTL and testbench

Registered 32-bit 1-to-8 demultiplexer bank: the write-side counterpart of the 32-bit 8-to-1 read mux. A 32-bit input word is steered by `{s2,s1,s0}` into one of eight 32-bit holding registers, `a`..`h`, which drive the mux inputs directly. A sequential clear engine empties all eight registers, one per cycle. The block sits in the ALU datapath as the operand/result staging bank feeding the 8-to-1 selector.

---
 rtl/dmx8_32bits_reg_pkg.sv | 13 +
 rtl/dmx8_32bits_reg_dec3_8.sv | 15 +
 rtl/dmx8_32bits_reg.sv | 115 +++++++++++
 tb/tb_dmx8_32bits_reg.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dmx8_32bits_reg_pkg.sv
// Shared sizing and FSM encoding for the 8-entry, 32-bit demux holding bank.
package dmx8_32bits_reg_pkg;

    localparam int REG_W = 32;
    localparam int N_REG = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/dmx8_32bits_reg_dec3_8.sv
// Combinational 3-to-8 one-hot decoder, used for both the write select and the sweep index.
module dec3_8
    import dmx8_32bits_reg_pkg::*;
(
    input  logic [SEL_W-1:0] sel,
    output logic [N_REG-1:0] onehot
);

    generate
        for (genvar gi = 0; gi < N_REG; gi++) begin : g_bit
            assign onehot[gi] = (sel == SEL_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/dmx8_32bits_reg.sv
// Registered 1-to-8 demux bank of 32-bit holding registers with a one-per-cycle clear sweep.
module dmx8_32bits_reg
    import dmx8_32bits_reg_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [REG_W-1:0] d,
    input  logic             s2,
    input  logic             s1,
    input  logic             s0,
    input  logic             we,
    input  logic             clr,
    output logic             ready,
    output logic             busy,
    output logic             clr_done,
    output logic [REG_W-1:0] a,
    output logic [REG_W-1:0] b,
    output logic [REG_W-1:0] c,
    output logic [REG_W-1:0] d_o,
    output logic [REG_W-1:0] e,
    output logic [REG_W-1:0] f,
    output logic [REG_W-1:0] g,
    output logic [REG_W-1:0] h,
    output logic [N_REG-1:0] vld
);

    state_t             state_reg;
    logic [SEL_W-1:0]   cnt_reg;
    logic               clr_done_reg;

    logic [N_REG-1:0]   wr_onehot;
    logic [N_REG-1:0]   clr_onehot;
    logic [N_REG-1:0]   reg_en;
    logic               wr_en;
    logic [REG_W-1:0]   data_q [N_REG];

    assign ready    = (state_reg == IDLE) & ~clr;
    assign busy     = (state_reg == CLEAR);
    assign clr_done = clr_done_reg;
    assign wr_en    = we & ready;

    dec3_8 u_dec_wr (
        .sel    ({s2, s1, s0}),
        .onehot (wr_onehot)
    );

    dec3_8 u_dec_clr (
        .sel    (cnt_reg),
        .onehot (clr_onehot)
    );

    assign reg_en = (wr_onehot & {N_REG{wr_en}}) | (clr_onehot & {N_REG{busy}});

    // clr_done is registered one cycle early so it is high exactly while cnt==7.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            clr_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    clr_done_reg <= 1'b0;
                    if (clr) begin
                        state_reg <= CLEAR;
                        cnt_reg   <= '0;
                    end
                end
                CLEAR: begin
                    cnt_reg      <= cnt_reg + 3'd1;
                    clr_done_reg <= (cnt_reg == 3'd6);
                    if (cnt_reg == 3'd7) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    cnt_reg      <= '0;
                    clr_done_reg <= 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < N_REG; gi++) begin : g_reg
            logic [REG_W-1:0] data_reg;
            logic             vld_reg;

            // Writes and sweep never coincide because ready is low throughout CLEAR.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    data_reg <= '0;
                    vld_reg  <= 1'b0;
                end else if (reg_en[gi]) begin
                    data_reg <= busy ? '0 : d;
                    vld_reg  <= ~busy;
                end
            end

            assign data_q[gi] = data_reg;
            assign vld[gi]    = vld_reg;
        end
    endgenerate

    assign a   = data_q[0];
    assign b   = data_q[1];
    assign c   = data_q[2];
    assign d_o = data_q[3];
    assign e   = data_q[4];
    assign f   = data_q[5];
    assign g   = data_q[6];
    assign h   = data_q[7];

endmodule

// File: tb/tb_dmx8_32bits_reg.sv
// Directed self-checking bench for the demux holding bank: writes, clear sweep, priority, reset abort.
module tb_dmx8_32bits_reg;

    logic        clk;
    logic        reset_n;
    logic [31:0] d_in;
    logic        s2, s1, s0;
    logic        we;
    logic        clr;
    logic        ready, busy, clr_done;
    logic [31:0] a, b, c, d_o, e, f, g, h;
    logic [7:0]  vld;
    logic [31:0] regs_o [8];

    int tests_run;
    int tests_failed;

    dmx8_32bits_reg dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .d        (d_in),
        .s2       (s2),
        .s1       (s1),
        .s0       (s0),
        .we       (we),
        .clr      (clr),
        .ready    (ready),
        .busy     (busy),
        .clr_done (clr_done),
        .a        (a),
        .b        (b),
        .c        (c),
        .d_o      (d_o),
        .e        (e),
        .f        (f),
        .g        (g),
        .h        (h),
        .vld      (vld)
    );

    assign regs_o[0] = a;
    assign regs_o[1] = b;
    assign regs_o[2] = c;
    assign regs_o[3] = d_o;
    assign regs_o[4] = e;
    assign regs_o[5] = f;
    assign regs_o[6] = g;
    assign regs_o[7] = h;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [2:0] sel, input logic [31:0] val);
        {s2, s1, s0} = sel;
        d_in = val;
        we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    logic [31:0] exp_regs [8];

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset_n = 1'b0;
        d_in = '0;
        {s2, s1, s0} = 3'd0;
        we = 1'b0;
        clr = 1'b0;

        // Reset state
        #12;
        check("rst_a", a, 32'h0);
        check("rst_h", h, 32'h0);
        check("rst_vld", {24'h0, vld}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_clr_done", {31'h0, clr_done}, 32'h0);
        check("rst_ready", {31'h0, ready}, 32'h1);
        reset_n = 1'b1;
        tick();
        check("idle_ready", {31'h0, ready}, 32'h1);
        check("idle_busy", {31'h0, busy}, 32'h0);

        // Single write to sel 5
        write_reg(3'd5, 32'hDEADBEEF);
        check("wr5_f", f, 32'hDEADBEEF);
        check("wr5_vld", {24'h0, vld}, 32'h20);
        check("wr5_a", a, 32'h0);
        check("wr5_e", e, 32'h0);
        check("wr5_g", g, 32'h0);

        // Fill all eight, then overwrite c
        for (int i = 0; i < 8; i++) begin
            write_reg(3'(i), 32'(i + 1));
            exp_regs[i] = 32'(i + 1);
        end
        for (int i = 0; i < 8; i++) begin
            check($sformatf("fill_reg%0d", i), regs_o[i], exp_regs[i]);
        end
        check("fill_vld", {24'h0, vld}, 32'hFF);
        write_reg(3'd2, 32'h0000CAFE);
        exp_regs[2] = 32'h0000CAFE;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovw_reg%0d", i), regs_o[i], exp_regs[i]);
        end
        check("ovw_vld", {24'h0, vld}, 32'hFF);

        // Clear sweep
        clr = 1'b1;
        #1;
        check("clr_ready_low", {31'h0, ready}, 32'h0);
        tick();
        clr = 1'b0;
        check("sweep_busy_start", {31'h0, busy}, 32'h1);
        check("sweep_ready_start", {31'h0, ready}, 32'h0);
        check("sweep_a_held", a, 32'h1);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("sweep_done_pre%0d", k), {31'h0, clr_done}, (k == 7) ? 32'h1 : 32'h0);
            tick();
            exp_regs[k] = 32'h0;
            for (int i = 0; i < 8; i++) begin
                check($sformatf("sweep%0d_reg%0d", k, i), regs_o[i], exp_regs[i]);
            end
            check($sformatf("sweep%0d_busy", k), {31'h0, busy}, (k < 7) ? 32'h1 : 32'h0);
        end
        check("sweep_end_vld", {24'h0, vld}, 32'h0);
        check("sweep_end_ready", {31'h0, ready}, 32'h1);
        check("sweep_end_done", {31'h0, clr_done}, 32'h0);

        // we together with clr: clr wins, then writes during CLEAR are dropped
        {s2, s1, s0} = 3'd3;
        d_in = 32'h55;
        we = 1'b1;
        clr = 1'b1;
        #1;
        check("prio_ready", {31'h0, ready}, 32'h0);
        tick();
        clr = 1'b0;
        check("prio_vld", {24'h0, vld}, 32'h0);
        check("prio_busy", {31'h0, busy}, 32'h1);
        for (int k = 0; k < 8; k++) begin
            tick();
        end
        we = 1'b0;
        check("drop_d_o", d_o, 32'h0);
        check("drop_vld", {24'h0, vld}, 32'h0);
        check("drop_busy", {31'h0, busy}, 32'h0);

        // Reset during the sweep
        for (int i = 0; i < 8; i++) begin
            write_reg(3'(i), 32'h10 + 32'(i));
        end
        check("pre_abort_vld", {24'h0, vld}, 32'hFF);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        tick();
        tick();
        check("pre_abort_c", c, 32'h0);
        check("pre_abort_d_o", d_o, 32'h13);
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("abort_reg%0d", i), regs_o[i], 32'h0);
        end
        check("abort_vld", {24'h0, vld}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_done", {31'h0, clr_done}, 32'h0);
        tick();
        check("abort_hold_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("post_abort_busy", {31'h0, busy}, 32'h0);
        check("post_abort_done", {31'h0, clr_done}, 32'h0);
        write_reg(3'd0, 32'h77);
        check("post_abort_a", a, 32'h77);
        check("post_abort_vld", {24'h0, vld}, 32'h01);
        check("post_abort_h", h, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
